// File: rtl/coherent_average_mc.sv
// Coherent averager: accumulates N periods of M samples into y[], then streams
// y[h] >>> SHIFT out through a valid/ready port. Sample path is a 3-stage read-modify-write.
module coherent_average_mc #(
    parameter int M     = 32,
    parameter int N     = 4,
    parameter int DW    = 12,
    parameter int QW    = 32,
    parameter int SHIFT = 0
) (
    input  logic          clk_rapido,
    input  logic          reset_n,
    input  logic          start,
    input  logic          sync,
    input  logic [DW-1:0] x,
    input  logic          x_valid,
    output logic [QW-1:0] data_out,
    output logic          data_out_valid,
    input  logic          data_out_ready,
    output logic          busy,
    output logic          done
);

    localparam int AW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (N > 0) ? $clog2(N + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX    = AW'(M - 1);
    localparam logic [KW-1:0] LAST_PERIOD = KW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_SYNC,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic signed [QW-1:0] r_y [M];

    logic [AW-1:0] r_clrAddr;
    logic [AW-1:0] r_n;
    logic [KW-1:0] r_k;
    logic          r_allIn;
    logic [AW-1:0] r_h;
    logic          r_outValid;
    logic [QW-1:0] r_dataOut;
    logic          r_done;

    logic                 r_aValid;
    logic [AW-1:0]        r_aAddr;
    logic signed [DW-1:0] r_aX;
    logic signed [QW-1:0] r_aRd;
    logic                 r_bValid;
    logic [AW-1:0]        r_bAddr;
    logic signed [QW-1:0] r_bSum;
    logic                 r_cValid;
    logic [AW-1:0]        r_cAddr;
    logic signed [QW-1:0] r_cSum;

    logic                 w_accept;
    logic                 w_xfer;
    logic [AW-1:0]        w_hNext;
    logic signed [QW-1:0] w_base;
    logic signed [QW-1:0] w_sum;

    assign w_accept = x_valid && (((r_state == S_WAIT_SYNC) && sync) ||
                                  ((r_state == S_ACCUM) && !r_allIn));
    assign w_xfer   = (r_state == S_DRAIN) && r_outValid && data_out_ready;
    assign w_hNext  = r_h + AW'(1);

    // Stage-A read misses the write retiring on its own edge (now in C) and the one
    // retiring next edge (in B); the newer of those wins.
    always_comb begin
        w_base = r_aRd;
        if (r_bValid && (r_bAddr == r_aAddr)) begin
            w_base = r_bSum;
        end else if (r_cValid && (r_cAddr == r_aAddr)) begin
            w_base = r_cSum;
        end
        w_sum = w_base + QW'(r_aX);
    end

    always_ff @(posedge clk_rapido or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:      if (start) w_stateNext = S_CLEAR;
            S_CLEAR:     if (r_clrAddr == LAST_IDX) w_stateNext = S_WAIT_SYNC;
            S_WAIT_SYNC: if (w_accept) w_stateNext = S_ACCUM;
            S_ACCUM:     if (r_allIn && !r_aValid && !r_bValid) w_stateNext = S_DRAIN;
            S_DRAIN:     if (w_xfer && (r_h == LAST_IDX)) w_stateNext = S_IDLE;
            default:     w_stateNext = S_IDLE;
        endcase
    end

    // Run bookkeeping: clear index, sample/period counters, readout index and output register.
    always_ff @(posedge clk_rapido or negedge reset_n) begin
        if (!reset_n) begin
            r_clrAddr  <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_allIn    <= 1'b0;
            r_h        <= '0;
            r_outValid <= 1'b0;
            r_dataOut  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_clrAddr <= '0;
                r_n       <= '0;
                r_k       <= '0;
                r_allIn   <= 1'b0;
                r_h       <= '0;
            end
            if (r_state == S_CLEAR) begin
                r_clrAddr <= r_clrAddr + AW'(1);
            end
            if (w_accept) begin
                if (r_n == LAST_IDX) begin
                    r_n <= '0;
                    r_k <= r_k + KW'(1);
                    if (r_k == LAST_PERIOD) begin
                        r_allIn <= 1'b1;
                    end
                end else begin
                    r_n <= r_n + AW'(1);
                end
            end
            if (r_state == S_DRAIN) begin
                if (!r_outValid) begin
                    r_outValid <= 1'b1;
                    r_dataOut  <= r_y[r_h] >>> SHIFT;
                end else if (data_out_ready) begin
                    if (r_h == LAST_IDX) begin
                        r_outValid <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_h       <= w_hNext;
                        r_dataOut <= r_y[w_hNext] >>> SHIFT;
                    end
                end
            end
        end
    end

    // Accumulate pipeline: A = read issued, B = sum computed, C = write just retired.
    always_ff @(posedge clk_rapido or negedge reset_n) begin
        if (!reset_n) begin
            r_aValid <= 1'b0;
            r_aAddr  <= '0;
            r_aX     <= '0;
            r_aRd    <= '0;
            r_bValid <= 1'b0;
            r_bAddr  <= '0;
            r_bSum   <= '0;
            r_cValid <= 1'b0;
            r_cAddr  <= '0;
            r_cSum   <= '0;
        end else begin
            r_aValid <= w_accept;
            if (w_accept) begin
                r_aAddr <= r_n;
                r_aX    <= x;
                r_aRd   <= r_y[r_n];
            end
            r_bValid <= r_aValid;
            if (r_aValid) begin
                r_bAddr <= r_aAddr;
                r_bSum  <= w_sum;
            end
            r_cValid <= r_bValid;
            r_cAddr  <= r_bAddr;
            r_cSum   <= r_bSum;
        end
    end

    always_ff @(posedge clk_rapido) begin
        if (r_state == S_CLEAR) begin
            r_y[r_clrAddr] <= '0;
        end else if (r_bValid) begin
            r_y[r_bAddr] <= r_bSum;
        end
    end

    assign data_out       = r_dataOut;
    assign data_out_valid = r_outValid;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_coherent_average_mc.sv
// Drives two averagers (SHIFT=0 and SHIFT=1) with the same stream and checks their
// outputs against per-index sums computed directly from the accepted sample list.
module tb_coherent_average_mc;

    localparam int M  = 4;
    localparam int N  = 2;
    localparam int DW = 12;
    localparam int QW = 32;

    logic          clk_rapido = 1'b0;
    logic          reset_n;
    logic          start;
    logic          sync;
    logic [DW-1:0] x;
    logic          x_valid;
    logic          data_out_ready;
    logic [QW-1:0] dataOut0, dataOut1;
    logic          valid0, valid1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    int stimX[$];
    bit stimSync[$];
    bit stimValid[$];
    logic signed [QW-1:0] expSum [M];

    always #5 clk_rapido = ~clk_rapido;

    coherent_average_mc #(.M(M), .N(N), .DW(DW), .QW(QW), .SHIFT(0)) u_dut0 (
        .clk_rapido(clk_rapido), .reset_n(reset_n), .start(start), .sync(sync),
        .x(x), .x_valid(x_valid), .data_out(dataOut0), .data_out_valid(valid0),
        .data_out_ready(data_out_ready), .busy(busy0), .done(done0)
    );

    coherent_average_mc #(.M(M), .N(N), .DW(DW), .QW(QW), .SHIFT(1)) u_dut1 (
        .clk_rapido(clk_rapido), .reset_n(reset_n), .start(start), .sync(sync),
        .x(x), .x_valid(x_valid), .data_out(dataOut1), .data_out_valid(valid1),
        .data_out_ready(data_out_ready), .busy(busy1), .done(done1)
    );

    task automatic checkVal(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic clearStim();
        stimX.delete();
        stimSync.delete();
        stimValid.delete();
    endtask

    task automatic addSample(input int xv, input bit s, input bit v);
        stimX.push_back(xv);
        stimSync.push_back(s);
        stimValid.push_back(v);
    endtask

    // Reference: skip until the first valid+sync, then the next M*N valid samples
    // land at index (count mod M); everything else is ignored.
    task automatic computeExpected();
        int  cnt;
        bit  started;
        cnt = 0;
        started = 0;
        for (int i = 0; i < M; i++) expSum[i] = 0;
        for (int i = 0; i < stimX.size(); i++) begin
            if (!stimValid[i]) continue;
            if (!started) begin
                if (!stimSync[i]) continue;
                started = 1;
            end
            if (cnt < M * N) begin
                expSum[cnt % M] = expSum[cnt % M] + stimX[i];
                cnt++;
            end
        end
    endtask

    task automatic startRun(input bit noise);
        @(negedge clk_rapido);
        start = 1'b1;
        @(negedge clk_rapido);
        start = 1'b0;
        checkVal("busy after start", {31'b0, busy0}, 1);
        for (int i = 0; i < M - 1; i++) begin
            x_valid = noise;
            sync    = noise;
            x       = DW'($urandom_range(0, 4095));
            @(negedge clk_rapido);
        end
        x_valid = 1'b0;
        sync    = 1'b0;
        repeat (3) @(negedge clk_rapido);
    endtask

    task automatic applyStimulus(input bit startNoise);
        for (int i = 0; i < stimX.size(); i++) begin
            x       = DW'(stimX[i]);
            sync    = stimSync[i];
            x_valid = stimValid[i];
            start   = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk_rapido);
        end
        x_valid = 1'b0;
        sync    = 1'b0;
        start   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int readyMode);
        int            xfers;
        int            doneCnt;
        int            cyc;
        int            pat;
        bit            r;
        bit            prevStall;
        logic [QW-1:0] prevData0, prevData1;
        logic signed [QW-1:0] expHalf;
        computeExpected();
        xfers = 0;
        doneCnt = 0;
        cyc = 0;
        pat = 0;
        prevStall = 0;
        prevData0 = '0;
        prevData1 = '0;
        while (xfers < M && cyc < 300) begin
            if (done0) doneCnt++;
            if (prevStall) begin
                checkVal({tag, " stall valid"}, {31'b0, valid0}, 1);
                checkVal({tag, " stall data0"}, dataOut0, prevData0);
                checkVal({tag, " stall data1"}, dataOut1, prevData1);
            end
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (pat % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pat++;
            data_out_ready = r;
            if (valid0 && r) begin
                expHalf = expSum[xfers] >>> 1;
                checkVal($sformatf("%s out0[%0d]", tag, xfers), dataOut0, expSum[xfers]);
                checkVal($sformatf("%s out1[%0d]", tag, xfers), dataOut1, expHalf);
                xfers++;
            end
            prevStall = valid0 && !r;
            prevData0 = dataOut0;
            prevData1 = dataOut1;
            @(negedge clk_rapido);
            cyc++;
        end
        checkVal({tag, " transfers"}, xfers, M);
        if (done0) doneCnt++;
        checkVal({tag, " valid after last"}, {31'b0, valid0}, 0);
        checkVal({tag, " busy after last"}, {31'b0, busy0}, 0);
        data_out_ready = 1'b0;
        @(negedge clk_rapido);
        if (done0) doneCnt++;
        checkVal({tag, " done pulses"}, doneCnt, 1);
    endtask

    initial begin
        int pre;
        int acc;
        reset_n = 1'b0;
        start = 1'b0;
        sync = 1'b0;
        x = '0;
        x_valid = 1'b0;
        data_out_ready = 1'b0;
        repeat (2) @(negedge clk_rapido);
        checkVal("reset data_out", dataOut0, 0);
        checkVal("reset valid", {31'b0, valid0}, 0);
        checkVal("reset busy", {31'b0, busy0}, 0);
        checkVal("reset done", {31'b0, done0}, 0);
        reset_n = 1'b1;
        @(negedge clk_rapido);

        $display("[TB] constant 5 run");
        clearStim();
        addSample(5, 1, 1);
        for (int i = 0; i < 7; i++) addSample(5, 0, 1);
        startRun(1);
        applyStimulus(0);
        checkOutput("const5", 0);

        $display("[TB] mixed values run");
        clearStim();
        for (int p = 0; p < 2; p++) begin
            addSample(100, p == 0, 1);
            addSample(-3, 0, 1);
            addSample(0, 0, 1);
            addSample(2047, 0, 1);
        end
        startRun(0);
        applyStimulus(0);
        checkOutput("mixed", 0);

        $display("[TB] pre-sync discard run");
        clearStim();
        for (int i = 0; i < 3; i++) addSample(7, 0, 1);
        addSample(1, 1, 1);
        for (int i = 0; i < 7; i++) addSample(1, 0, 1);
        startRun(0);
        applyStimulus(0);
        checkOutput("presync", 0);

        $display("[TB] ready toggle run");
        clearStim();
        addSample(int'($urandom_range(0, 4095)) - 2048, 1, 1);
        for (int i = 0; i < M * N - 1; i++) addSample(int'($urandom_range(0, 4095)) - 2048, 0, 1);
        startRun(0);
        applyStimulus(0);
        checkOutput("toggle", 1);

        $display("[TB] mid-run reset");
        clearStim();
        addSample(9, 1, 1);
        for (int i = 0; i < 4; i++) addSample(9, 0, 1);
        startRun(0);
        applyStimulus(0);
        checkVal("busy before abort", {31'b0, busy0}, 1);
        #2 reset_n = 1'b0;
        #1;
        checkVal("abort busy", {31'b0, busy0}, 0);
        checkVal("abort valid", {31'b0, valid0}, 0);
        checkVal("abort data_out", dataOut0, 0);
        @(negedge clk_rapido);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x_valid = 1'b1;
            sync = 1'b1;
            x = DW'($urandom_range(0, 4095));
            @(negedge clk_rapido);
        end
        x_valid = 1'b0;
        sync = 1'b0;
        checkVal("no output without start", {31'b0, valid0}, 0);
        checkVal("idle without start", {31'b0, busy0}, 0);
        clearStim();
        addSample(1, 1, 1);
        for (int i = 0; i < 7; i++) addSample(1, 0, 1);
        startRun(0);
        applyStimulus(1);
        checkOutput("after abort", 0);

        $display("[TB] randomized runs");
        for (int run = 0; run < 5; run++) begin
            clearStim();
            pre = $urandom_range(0, 3);
            for (int i = 0; i < pre; i++) begin
                addSample(int'($urandom_range(0, 4095)) - 2048, 0, 1'($urandom_range(0, 1)));
            end
            addSample(int'($urandom_range(0, 4095)) - 2048, 1, 1);
            acc = 1;
            while (acc < M * N + 2) begin
                if ($urandom_range(0, 3) == 0) begin
                    addSample(int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 1)), 0);
                end else begin
                    addSample(int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 1)), 1);
                    acc++;
                end
            end
            startRun(1'($urandom_range(0, 1)));
            applyStimulus(0);
            checkOutput($sformatf("random%0d", run), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coherent_average_mc.md
COHERENT_AVERAGE_MC -- requirements
Module: coherent_average_mc

Interface
REQ-001 SHALL have parameter M, default 32: samples per period (accumulator depth), M >= 2.
REQ-002 SHALL have parameter N, default 4: periods accumulated per run, N >= 1.
REQ-003 SHALL have parameter DW, default 12: input sample width, two's complement.
REQ-004 SHALL have parameter QW, default 32: accumulator and output width, QW >= DW + ceil(log2 N).
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied on readout (mean when N = 2^SHIFT).
REQ-006 SHALL have port clk_rapido, input, 1: the only clock; all logic rising-edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: run request, sampled in IDLE only.
REQ-009 SHALL have port sync, input, 1: period-start marker, qualified by x_valid.
REQ-010 SHALL have port x, input, DW: signed sample.
REQ-011 SHALL have port x_valid, input, 1: sample strobe.
REQ-012 SHALL have port data_out, output, QW: averaged point.
REQ-013 SHALL have port data_out_valid, output, 1: data_out holds a point.
REQ-014 SHALL have port data_out_ready, input, 1: consumer accepts; transfer = valid && ready.
REQ-015 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on run completion.

Function
REQ-017 SHALL implement FSM IDLE -> CLEAR -> WAIT_SYNC -> ACCUM -> DRAIN -> IDLE.
REQ-018 IDLE: start=1 SHALL enter CLEAR next cycle; start in any other state SHALL be ignored.
REQ-019 CLEAR: SHALL write 0 to y[0..M-1], one address per cycle, exactly M cycles, then WAIT_SYNC.
REQ-020 WAIT_SYNC: samples without sync SHALL be discarded; first x_valid && sync SHALL be accepted as index 0 and enter ACCUM.
REQ-021 ACCUM: each accepted sample SHALL update y[n] <= y[n] + sign_extend(x), n = 0..M-1 wrapping to 0; gaps in x_valid SHALL stall without loss.
REQ-022 ACCUM: sync SHALL be ignored after acceptance of the first sample (no realignment mid-run).
REQ-023 Back-to-back x_valid every cycle SHALL produce exact sums; internal read-modify-write hazards SHALL be resolved by forwarding, not by dropping or stalling input.
REQ-024 Period counter k SHALL increment when the sample at n = M-1 is accepted; when k reaches N the FSM SHALL enter DRAIN after all pending writes have retired.
REQ-025 Arithmetic SHALL be signed, modulo 2^QW (wrap, no saturation).
REQ-026 DRAIN: SHALL present data_out = y[h] >>> SHIFT (sign-preserving) for h = 0..M-1 in order.
REQ-027 data_out and data_out_valid SHALL stay stable while valid && !ready; h SHALL advance only on transfer.
REQ-028 Transfers SHALL sustain one per cycle with ready held high.
REQ-029 Transfer of h = M-1 SHALL drop data_out_valid next cycle, pulse done for one cycle, and return to IDLE.
REQ-030 x_valid outside WAIT_SYNC/ACCUM SHALL have no effect on y.

Reset
REQ-031 reset_n low SHALL force IDLE, n = k = h = 0, data_out = 0, data_out_valid = 0, busy = 0, done = 0, asynchronously.
REQ-032 Reset mid-run SHALL abort it; y contents are undefined until the next CLEAR, and no output SHALL appear without a new start.

Verification (M=4, N=2, DW=12, QW=32, SHIFT=0 unless stated)
REQ-033 Start, sync with first sample, 8 consecutive x=5 -> exactly four transfers of 10, done pulse, busy low.
REQ-034 x = 100, -3, 0, 2047 repeated twice, SHIFT=1 -> outputs 100, -3, 0, 2047 (sums 200, -6, 0, 4094 shifted).
REQ-035 Three samples x=7 with sync=0, then sync with x=1 and 7 further x=1 -> four outputs of 2 (pre-sync samples discarded).
REQ-036 data_out_ready toggled 1,0,0,1,... during DRAIN -> data_out stable while stalled, four distinct in-order transfers, no duplicates or drops.
REQ-037 reset_n pulsed low after 5 samples, then a new full run of x=1 -> outputs 2 each (CLEAR erased stale partial sums); start pulses during busy ignored.
